// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one shift/subtract step per clock, start/busy/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (magnitude divide, signs fixed on finish).
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] wq_q, wq_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
`ifdef SIGNED_DIV_EN
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
`endif

  logic [WIDTH-1:0] a_mag, b_mag, wq_n, q_res, r_res;
  logic [WIDTH+1:0] prem_s, diff;
  logic [WIDTH:0]   prem_n;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wq_d    = wq_q;
    prem_d  = prem_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
    a_mag = dividend;
    b_mag = divisor;
`endif

    // One restoring step; a negative trial difference keeps the shifted remainder.
    prem_s = {prem_q, wq_q[WIDTH-1]};
    diff   = prem_s - {2'b00, dvs_q};
    wq_n   = {wq_q[WIDTH-2:0], ~diff[WIDTH+1]};
    prem_n = diff[WIDTH+1] ? prem_s[WIDTH:0] : diff[WIDTH:0];

`ifdef SIGNED_DIV_EN
    q_res = neg_quot_q ? -wq_n : wq_n;
    r_res = neg_rem_q  ? -prem_n[WIDTH-1:0] : prem_n[WIDTH-1:0];
`else
    q_res = wq_n;
    r_res = prem_n[WIDTH-1:0];
`endif

    case (state_q)
      RUN: begin
        wq_d   = wq_n;
        prem_d = prem_n;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = FINISH;
          if (zero_q) begin
            quot_d = '1;
            rem_d  = wq_q;
            dbz_d  = 1'b1;
          end else begin
            quot_d = q_res;
            rem_d  = r_res;
            dbz_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          prem_d  = '0;
          dvs_d   = b_mag;
`ifdef SIGNED_DIV_EN
          neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_d  = dividend[WIDTH-1];
`endif
          // A zero divisor spends a single RUN cycle so done lands one edge after start.
          if (divisor == '0) begin
            zero_d = 1'b1;
            wq_d   = dividend;
            cnt_d  = LAST;
          end else begin
            zero_d = 1'b0;
            wq_d   = a_mag;
            cnt_d  = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wq_q    <= '0;
      prem_q  <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wq_q    <= wq_d;
      prem_q  <= prem_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == FINISH);

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference model.
// Honours SIGNED_DIV_EN the same way as the design.
module tb_seq_divider;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division as defined for the active build.
  function automatic void refDiv(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                 output logic z);
    int sa, sb, sq, sr;
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      z = 1'b0;
`ifdef SIGNED_DIV_EN
      sa = $signed(a);
      sb = $signed(b);
      if (sa == -32768 && sb == -1) begin
        sq = -32768;
        sr = 0;
      end else begin
        sq = sa / sb;
        sr = sa % sb;
      end
`else
      sa = int'(a);
      sb = int'(b);
      sq = sa / sb;
      sr = sa % sb;
`endif
      q = sq[WIDTH-1:0];
      r = sr[WIDTH-1:0];
    end
  endfunction

  // Called #1 after a rising edge; start is sampled at the next edge.
  task automatic startOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (b != 0) checkOutput("busy_after_start", busy, 1);
  endtask

  task automatic waitDone(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] eq, er;
    logic ez;
    int lat;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    refDiv(a, b, eq, er, ez);
    checkOutput("latency", lat, (b == 0) ? 1 : WIDTH);
    checkOutput("quotient", quotient, eq);
    checkOutput("remainder", remainder, er);
    checkOutput("div_by_zero", div_by_zero, ez);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    startOp(a, b);
    waitDone(a, b);
    @(posedge clk);
    #1;
    checkOutput("done_single_pulse", done, 0);
  endtask

  initial begin
    int dones;
    logic [WIDTH-1:0] ra, rb;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_quotient", quotient, 0);
    checkOutput("rst_remainder", remainder, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(16'd100, 16'd7);
    applyStimulus(16'hFFFF, 16'd1);
    applyStimulus(16'd3, 16'hFFFF);
    applyStimulus(16'd5, 16'd0);
    applyStimulus(16'd9, 16'd3);

    // Start pulsed mid-run must be ignored.
    startOp(16'd50, 16'd5);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    dividend = 16'd1;
    divisor  = 16'd1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        checkOutput("midrun_quotient", quotient, 10);
        checkOutput("midrun_remainder", remainder, 0);
      end
    end
    checkOutput("midrun_done_count", dones, 1);

    // Back-to-back chain: each new start issued in the previous FINISH cycle.
    startOp(16'd1234, 16'd10);
    waitDone(16'd1234, 16'd10);
    startOp(16'd7, 16'd0);
    waitDone(16'd7, 16'd0);
    startOp(16'd40000, 16'd321);
    waitDone(16'd40000, 16'd321);
    @(posedge clk);
    #1;
    checkOutput("b2b_done_low", done, 0);

    // Random mix, some issued back-to-back, some divisors zero or small.
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = WIDTH'($urandom_range(1, 15));
        default: rb = WIDTH'($urandom);
      endcase
      startOp(ra, rb);
      waitDone(ra, rb);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
        checkOutput("rand_done_pulse", done, 0);
      end
    end
    @(posedge clk);
    #1;

    // Reset mid-operation aborts silently and clears outputs.
    applyStimulus(16'd200, 16'd9);
    startOp(16'd1000, 16'd3);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_quotient", quotient, 0);
    checkOutput("midrst_remainder", remainder, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_dbz", div_by_zero, 0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    checkOutput("midrst_no_done", dones, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(16'd1000, 16'd3);

`ifdef SIGNED_DIV_EN
    applyStimulus(16'hFFF9, 16'd2);
    applyStimulus(16'd7, 16'hFFFE);
    applyStimulus(16'h8000, 16'hFFFF);
    applyStimulus(16'hFFF9, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
